// File: rtl/pwm_pkg.sv
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared state encoding and default dead-time width for the
//                pwm_deadtime block. FAULT state exists only when
//                PWM_DEADTIME_FAULT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int c_DT_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOW_ON  = 3'd1,
        ST_DT_RISE = 3'd2,
        ST_HIGH_ON = 3'd3,
`ifdef PWM_DEADTIME_FAULT_EN
        ST_DT_FALL = 3'd4,
        ST_FAULT   = 3'd5
`else
        ST_DT_FALL = 3'd4
`endif
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dt_counter.sv
// ============================================================================
//  Module      : dt_counter
//  Description : Loadable dead-time down-counter; done while count <= 1,
//                saturates so it never wraps below zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dt_counter
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = c_DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [DT_WIDTH-1:0] load_value,
    input  logic                dec,
    output logic                done
);

    localparam logic [DT_WIDTH-1:0] c_ONE = DT_WIDTH'(1);

    logic [DT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count > c_ONE)) begin
            r_count <= r_count - c_ONE;
        end
    end

    // A load of 0 finishes after one cycle, same as a load of 1.
    assign done = (r_count <= c_ONE);

endmodule

`default_nettype wire

// File: rtl/pwm_deadtime.sv
// ============================================================================
//  Module      : pwm_deadtime
//  Description : Complementary PWM driver with dead-time insertion. Define
//                PWM_DEADTIME_FAULT_EN to add fault/fault_clr/fault_latched.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = c_DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
`ifdef PWM_DEADTIME_FAULT_EN
    input  logic                fault,
    input  logic                fault_clr,
    output logic                fault_latched,
`endif
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic                dt_active
);

    state_t r_state;
    state_t w_next_state;
    logic   w_load;
    logic   w_dec;
    logic   w_done;
    logic   r_pwm_hi;
    logic   r_pwm_lo;
    logic   r_dt_active;

    dt_counter #(
        .DT_WIDTH (DT_WIDTH)
    ) u_dt_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_load),
        .load_value (dead_time),
        .dec        (w_dec),
        .done       (w_done)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        if (!enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pwm_in) begin
                        w_next_state = ST_DT_RISE;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = ST_LOW_ON;
                    end
                end
                ST_LOW_ON: begin
                    if (pwm_in) begin
                        w_next_state = ST_DT_RISE;
                        w_load       = 1'b1;
                    end
                end
                ST_DT_RISE: begin
                    if (!pwm_in) begin
                        w_next_state = ST_LOW_ON;
                    end else if (w_done) begin
                        w_next_state = ST_HIGH_ON;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                ST_HIGH_ON: begin
                    if (!pwm_in) begin
                        w_next_state = ST_DT_FALL;
                        w_load       = 1'b1;
                    end
                end
                ST_DT_FALL: begin
                    if (pwm_in) begin
                        w_next_state = ST_HIGH_ON;
                    end else if (w_done) begin
                        w_next_state = ST_LOW_ON;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
`ifdef PWM_DEADTIME_FAULT_EN
        // Fault handling overrides the enable path; only reset ranks higher.
        if (r_state == ST_FAULT) begin
            w_next_state = (fault_clr && !fault) ? ST_IDLE : ST_FAULT;
            w_load       = 1'b0;
            w_dec        = 1'b0;
        end
        if (fault) begin
            w_next_state = ST_FAULT;
            w_load       = 1'b0;
            w_dec        = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_pwm_hi    <= 1'b0;
            r_pwm_lo    <= 1'b0;
            r_dt_active <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pwm_hi    <= (w_next_state == ST_HIGH_ON);
            r_pwm_lo    <= (w_next_state == ST_LOW_ON);
            r_dt_active <= (w_next_state == ST_DT_RISE) || (w_next_state == ST_DT_FALL);
        end
    end

`ifdef PWM_DEADTIME_FAULT_EN
    logic r_fault_latched;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fault_latched <= 1'b0;
        end else begin
            r_fault_latched <= (w_next_state == ST_FAULT);
        end
    end

    assign fault_latched = r_fault_latched;
`endif

    assign pwm_hi    = r_pwm_hi;
    assign pwm_lo    = r_pwm_lo;
    assign dt_active = r_dt_active;

endmodule

`default_nettype wire

// File: tb/tb_pwm_deadtime.sv
// ============================================================================
//  Module      : tb_pwm_deadtime
//  Description : Self-checking bench for pwm_deadtime with a cycle-level
//                behavioural reference model and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_deadtime;

    localparam int DT_WIDTH = 8;

    localparam int M_OFF    = 0;
    localparam int M_LOW    = 1;
    localparam int M_TO_HI  = 2;
    localparam int M_HIGH   = 3;
    localparam int M_TO_LO  = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                enable;
    logic                pwm_in;
    logic [DT_WIDTH-1:0] dead_time;
    logic                pwm_hi;
    logic                pwm_lo;
    logic                dt_active;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current mode plus how long the gap must last and
    // how many gap cycles have already been shown.
    int m_mode   = M_OFF;
    int m_need   = 0;
    int m_served = 0;

    always #5 clk = ~clk;

    pwm_deadtime #(
        .DT_WIDTH (DT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .dead_time (dead_time),
        .pwm_hi    (pwm_hi),
        .pwm_lo    (pwm_lo),
        .dt_active (dt_active)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void start_gap(input int to_mode);
        m_mode   = to_mode;
        m_need   = (dead_time == 0) ? 1 : int'(dead_time);
        m_served = 1;
    endfunction

    function automatic void model_step();
        if (!reset_n || !enable) begin
            m_mode = M_OFF;
        end else begin
            case (m_mode)
                M_OFF:   if (pwm_in) start_gap(M_TO_HI); else m_mode = M_LOW;
                M_LOW:   if (pwm_in) start_gap(M_TO_HI);
                M_HIGH:  if (!pwm_in) start_gap(M_TO_LO);
                M_TO_HI: begin
                    if (!pwm_in)                m_mode = M_LOW;
                    else if (m_served >= m_need) m_mode = M_HIGH;
                    else                         m_served++;
                end
                default: begin
                    if (pwm_in)                  m_mode = M_HIGH;
                    else if (m_served >= m_need) m_mode = M_LOW;
                    else                         m_served++;
                end
            endcase
        end
    endfunction

    task automatic step(input string tag);
        logic [2:0] exp_vec;
        @(posedge clk);
        model_step();
        #1;
        exp_vec = {m_mode == M_HIGH, m_mode == M_LOW, (m_mode == M_TO_HI) || (m_mode == M_TO_LO)};
        check_val(tag, {29'd0, pwm_hi, pwm_lo, dt_active}, {29'd0, exp_vec});
        check_val("no_overlap", {31'd0, pwm_hi & pwm_lo}, 32'd0);
    endtask

    // Count consecutive dead-time cycles following the current input change;
    // optionally swap dead_time right after the first gap cycle.
    task automatic count_gap(input string tag, input int exp_len, input int new_dt);
        int len;
        len = 0;
        for (int i = 0; i < 300; i++) begin
            step(tag);
            if (i == 0 && new_dt >= 0) dead_time = DT_WIDTH'(new_dt);
            if (dt_active) len++;
            else break;
        end
        check_val({tag, "_len"}, len, exp_len);
    endtask

    initial begin
        int run;
        int saw_hi;
        int hold;

        reset_n   = 1'b0;
        enable    = 1'b0;
        pwm_in    = 1'b0;
        dead_time = '0;
        repeat (3) step("reset");
        check_val("reset_outs", {29'd0, pwm_hi, pwm_lo, dt_active}, 32'd0);

        // Released from reset but disabled: nothing moves.
        reset_n = 1'b1;
        repeat (2) step("idle_hold");
        check_val("idle_outs", {29'd0, pwm_hi, pwm_lo, dt_active}, 32'd0);

        // Rising transition with dead_time = 3.
        enable    = 1'b1;
        dead_time = 8'd3;
        repeat (2) step("to_low");
        check_val("low_on", {31'd0, pwm_lo}, 32'd1);
        pwm_in = 1'b1;
        count_gap("rise_dt3", 3, -1);
        check_val("hi_after_dt3", {31'd0, pwm_hi}, 32'd1);

        // 100% duty: stays high, no further gaps.
        run = 0;
        repeat (20) begin
            step("hold_high");
            if (!pwm_hi) run++;
        end
        check_val("hold_high_steady", run, 0);

        // dead_time changed 4 -> 10 in the middle of a falling gap.
        dead_time = 8'd4;
        pwm_in    = 1'b0;
        count_gap("fall_dt4", 4, 10);
        check_val("lo_after_fall", {31'd0, pwm_lo}, 32'd1);
        pwm_in = 1'b1;
        count_gap("rise_dt10", 10, -1);
        pwm_in = 1'b0;
        count_gap("fall_dt10", 10, -1);

        // dead_time = 0 square wave, period 16: one both-low cycle per edge.
        dead_time = 8'd0;
        run = 0;
        for (int i = 0; i < 1000; i++) begin
            pwm_in = ((i / 8) % 2) == 1;
            step("dt0_sq");
            if (!pwm_hi && !pwm_lo) run++;
            else begin
                if (run != 0) check_val("dt0_gap", run, 1);
                run = 0;
            end
        end

        // Short pulse shorter than dead time: rise aborts, no high pulse.
        dead_time = 8'd5;
        pwm_in    = 1'b0;
        repeat (4) step("pre_abort");
        saw_hi = 0;
        pwm_in = 1'b1;
        repeat (2) begin step("abort"); if (pwm_hi) saw_hi++; end
        pwm_in = 1'b0;
        repeat (10) begin step("abort_after"); if (pwm_hi) saw_hi++; end
        check_val("abort_no_hi", saw_hi, 0);
        check_val("abort_low", {31'd0, pwm_lo}, 32'd1);

        // Reset in the middle of a rising gap (counter at 2).
        dead_time = 8'd3;
        pwm_in    = 1'b1;
        repeat (2) step("rise_pre_rst");
        reset_n = 1'b0;
        step("mid_rst");
        check_val("mid_rst_outs", {29'd0, pwm_hi, pwm_lo, dt_active}, 32'd0);
        reset_n = 1'b1;
        step("post_rst");
        check_val("post_rst_dt", {31'd0, dt_active}, 32'd1);
        repeat (4) step("post_rst_run");
        check_val("post_rst_hi", {31'd0, pwm_hi}, 32'd1);

        // Disable while high.
        enable = 1'b0;
        step("disable_hi");
        check_val("disable_outs", {29'd0, pwm_hi, pwm_lo, dt_active}, 32'd0);

        // Maximum dead time.
        enable    = 1'b1;
        pwm_in    = 1'b0;
        dead_time = 8'hFF;
        repeat (2) step("pre_max");
        pwm_in = 1'b1;
        count_gap("rise_max", 255, -1);

        // Randomized traffic against the model.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                pwm_in = 1'($urandom_range(0, 1));
                hold   = $urandom_range(1, 20);
            end
            hold--;
            if ($urandom_range(0, 15) == 0) dead_time = DT_WIDTH'($urandom_range(0, 12));
            enable  = ($urandom_range(0, 63) != 0);
            reset_n = ($urandom_range(0, 255) != 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
